instruction_decode: RTL and testbench

- Second stage of the 5-stage MIPS pipeline, directly downstream of the instruction fetch stage.
- Consumes the fetched instruction and PCNext, and decodes the control word.
- Reads a 32x32 register file, resolves beq/bne/j in ID, and feeds the branch target and select back to fetch.
- Detects load-use hazards, stalls fetch, and drives the registered ID/EX pipeline outputs.

---
 rtl/mips_pkg.sv | 56 +++++
 rtl/register_file.sv | 57 +++++
 rtl/instruction_decode.sv | 174 +++++++++++++++++
 tb/tb_instruction_decode.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: datapath widths, opcode constants, ALU operation
// classes, the decoded control word and the opcode -> control decoder.
package mips_pkg;

   localparam int unsigned PC_W       = 8;
   localparam int unsigned DATA_W     = 32;
   localparam int unsigned REG_ADDR_W = 5;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_R   = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_SLT = 3'd4;
   localparam logic [2:0] ALU_LUI = 3'd5;

   typedef struct packed {
      logic       reg_dst;
      logic       alu_src;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_write;
      logic [2:0] alu_op;
   } ctrl_t;

   // Branches, jumps and unknown opcodes have no EX-stage effect.
   function automatic ctrl_t decode_ctrl(input logic [5:0] op);
      ctrl_t c;
      c = '0;
      case (op)
         OP_RTYPE: c = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_R};
         OP_LW:    c = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, ALU_ADD};
         OP_SW:    c = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ALU_ADD};
         OP_ADDI:  c = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ALU_ADD};
         OP_ANDI:  c = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ALU_AND};
         OP_ORI:   c = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ALU_OR};
         OP_SLTI:  c = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ALU_SLT};
         OP_LUI:   c = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ALU_LUI};
         default:  c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/register_file.sv
// 32 x 32 register file: two combinational read ports, one write port.
// A write in the same cycle as a read of the same index is bypassed to the
// read port. Register 0 is hardwired to zero.
// Ports:
//   clk, rst              clock (rising edge), async active-low reset
//   en_i                  global enable, gates the write
//   we_i/waddr_i/wdata_i  write port
//   raddr_a_i/rdata_a_o   read port A
//   raddr_b_i/rdata_b_o   read port B
module register_file
   import mips_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en_i,
   input  logic                  we_i,
   input  logic [REG_ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0]     wdata_i,
   input  logic [REG_ADDR_W-1:0] raddr_a_i,
   input  logic [REG_ADDR_W-1:0] raddr_b_i,
   output logic [DATA_W-1:0]     rdata_a_o,
   output logic [DATA_W-1:0]     rdata_b_o
);

   localparam int unsigned NumRegs = 2 ** REG_ADDR_W;

   logic [DATA_W-1:0] regs_q [NumRegs];
   logic              wr_valid;

   assign wr_valid = we_i && (waddr_i != '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NumRegs; i++) begin
            regs_q[i] <= '0;
         end
      end else if (en_i && wr_valid) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   // Bypass follows the write request itself, not the enable.
   always_comb begin
      rdata_a_o = '0;
      if (raddr_a_i != '0) begin
         rdata_a_o = (wr_valid && (waddr_i == raddr_a_i)) ? wdata_i : regs_q[raddr_a_i];
      end
   end

   always_comb begin
      rdata_b_o = '0;
      if (raddr_b_i != '0) begin
         rdata_b_o = (wr_valid && (waddr_i == raddr_b_i)) ? wdata_i : regs_q[raddr_b_i];
      end
   end

endmodule

// File: rtl/instruction_decode.sv
// MIPS ID stage: decodes the control word, reads operands, resolves
// beq/bne/j back to fetch, detects load-use hazards and drives the
// registered ID/EX pipeline outputs.
// Ports:
//   clk, rst, enable           clock, async active-low reset, run enable
//   i_PCNext, i_instruction    instruction in ID and its PC+1
//   i_wb_*                     writeback port into the register file
//   o_PCSrc, o_PCBranch        combinational branch/jump decision and target
//   o_stall                    combinational load-use stall to fetch
//   o_* (remaining)            registered ID/EX fields and control
module instruction_decode
   import mips_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic [PC_W-1:0]       i_PCNext,
   input  logic [DATA_W-1:0]     i_instruction,
   input  logic                  i_wb_reg_write,
   input  logic [REG_ADDR_W-1:0] i_wb_addr,
   input  logic [DATA_W-1:0]     i_wb_data,
   output logic                  o_PCSrc,
   output logic [PC_W-1:0]       o_PCBranch,
   output logic                  o_stall,
   output logic [DATA_W-1:0]     o_rs_data,
   output logic [DATA_W-1:0]     o_rt_data,
   output logic [DATA_W-1:0]     o_imm,
   output logic [REG_ADDR_W-1:0] o_rs,
   output logic [REG_ADDR_W-1:0] o_rt,
   output logic [REG_ADDR_W-1:0] o_rd,
   output logic [4:0]            o_shamt,
   output logic [5:0]            o_funct,
   output logic                  o_RegDst,
   output logic                  o_ALUSrc,
   output logic                  o_MemRead,
   output logic                  o_MemWrite,
   output logic                  o_MemtoReg,
   output logic                  o_RegWrite,
   output logic [2:0]            o_ALUOp
);

   logic [5:0]            opcode;
   logic [REG_ADDR_W-1:0] rs_idx;
   logic [REG_ADDR_W-1:0] rt_idx;
   logic [DATA_W-1:0]     rs_val;
   logic [DATA_W-1:0]     rt_val;
   logic [DATA_W-1:0]     imm_ext;
   ctrl_t                 ctrl_dec;
   logic                  reads_rt;
   logic                  stall;
   logic                  pc_src;
   logic [PC_W-1:0]       pc_branch;

   ctrl_t                 ctrl_q;
   logic [DATA_W-1:0]     rs_data_q;
   logic [DATA_W-1:0]     rt_data_q;
   logic [DATA_W-1:0]     imm_q;
   logic [REG_ADDR_W-1:0] rs_q;
   logic [REG_ADDR_W-1:0] rt_q;
   logic [REG_ADDR_W-1:0] rd_q;
   logic [4:0]            shamt_q;
   logic [5:0]            funct_q;

   assign opcode = i_instruction[31:26];
   assign rs_idx = i_instruction[25:21];
   assign rt_idx = i_instruction[20:16];

   register_file u_register_file (
      .clk       (clk),
      .rst       (rst),
      .en_i      (enable),
      .we_i      (i_wb_reg_write),
      .waddr_i   (i_wb_addr),
      .wdata_i   (i_wb_data),
      .raddr_a_i (rs_idx),
      .raddr_b_i (rt_idx),
      .rdata_a_o (rs_val),
      .rdata_b_o (rt_val)
   );

   assign ctrl_dec = decode_ctrl(opcode);

   always_comb begin
      if ((opcode == OP_ANDI) || (opcode == OP_ORI)) begin
         imm_ext = {{(DATA_W - 16){1'b0}}, i_instruction[15:0]};
      end else begin
         imm_ext = {{(DATA_W - 16){i_instruction[15]}}, i_instruction[15:0]};
      end
   end

   // I-type ALU ops and lw overwrite rt rather than read it.
   always_comb begin
      reads_rt = 1'b0;
      case (opcode)
         OP_RTYPE, OP_SW, OP_BEQ, OP_BNE: reads_rt = 1'b1;
         default:                         reads_rt = 1'b0;
      endcase
   end

   assign stall = ctrl_q.mem_read && (rt_q != '0) &&
                  ((rt_q == rs_idx) || ((rt_q == rt_idx) && reads_rt));

   always_comb begin
      pc_src    = 1'b0;
      pc_branch = '0;
      case (opcode)
         OP_BEQ: begin
            pc_src    = (rs_val == rt_val);
            pc_branch = i_PCNext + i_instruction[PC_W-1:0];
         end
         OP_BNE: begin
            pc_src    = (rs_val != rt_val);
            pc_branch = i_PCNext + i_instruction[PC_W-1:0];
         end
         OP_J: begin
            pc_src    = 1'b1;
            pc_branch = i_instruction[PC_W-1:0];
         end
         default: begin
            pc_src    = 1'b0;
            pc_branch = '0;
         end
      endcase
      // Operands may be stale while the load is still in EX.
      if (stall) begin
         pc_src = 1'b0;
      end
   end

   assign o_PCSrc    = pc_src;
   assign o_PCBranch = pc_branch;
   assign o_stall    = stall;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ctrl_q    <= '0;
         rs_data_q <= '0;
         rt_data_q <= '0;
         imm_q     <= '0;
         rs_q      <= '0;
         rt_q      <= '0;
         rd_q      <= '0;
         shamt_q   <= '0;
         funct_q   <= '0;
      end else if (enable) begin
         ctrl_q    <= stall ? '0 : ctrl_dec;
         rs_data_q <= rs_val;
         rt_data_q <= rt_val;
         imm_q     <= imm_ext;
         rs_q      <= rs_idx;
         rt_q      <= rt_idx;
         rd_q      <= i_instruction[15:11];
         shamt_q   <= i_instruction[10:6];
         funct_q   <= i_instruction[5:0];
      end
   end

   assign o_rs_data  = rs_data_q;
   assign o_rt_data  = rt_data_q;
   assign o_imm      = imm_q;
   assign o_rs       = rs_q;
   assign o_rt       = rt_q;
   assign o_rd       = rd_q;
   assign o_shamt    = shamt_q;
   assign o_funct    = funct_q;
   assign o_RegDst   = ctrl_q.reg_dst;
   assign o_ALUSrc   = ctrl_q.alu_src;
   assign o_MemRead  = ctrl_q.mem_read;
   assign o_MemWrite = ctrl_q.mem_write;
   assign o_MemtoReg = ctrl_q.mem_to_reg;
   assign o_RegWrite = ctrl_q.reg_write;
   assign o_ALUOp    = ctrl_q.alu_op;

endmodule

// File: tb/tb_instruction_decode.sv
// Self-checking bench for instruction_decode: directed steps followed by a
// randomized run, all checked against a behavioural model of the ID stage.
module tb_instruction_decode;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [7:0]  i_PCNext;
   logic [31:0] i_instruction;
   logic        i_wb_reg_write;
   logic [4:0]  i_wb_addr;
   logic [31:0] i_wb_data;
   logic        o_PCSrc;
   logic [7:0]  o_PCBranch;
   logic        o_stall;
   logic [31:0] o_rs_data, o_rt_data, o_imm;
   logic [4:0]  o_rs, o_rt, o_rd, o_shamt;
   logic [5:0]  o_funct;
   logic        o_RegDst, o_ALUSrc, o_MemRead, o_MemWrite, o_MemtoReg, o_RegWrite;
   logic [2:0]  o_ALUOp;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   instruction_decode dut (
      .clk            (clk),
      .rst            (rst),
      .enable         (enable),
      .i_PCNext       (i_PCNext),
      .i_instruction  (i_instruction),
      .i_wb_reg_write (i_wb_reg_write),
      .i_wb_addr      (i_wb_addr),
      .i_wb_data      (i_wb_data),
      .o_PCSrc        (o_PCSrc),
      .o_PCBranch     (o_PCBranch),
      .o_stall        (o_stall),
      .o_rs_data      (o_rs_data),
      .o_rt_data      (o_rt_data),
      .o_imm          (o_imm),
      .o_rs           (o_rs),
      .o_rt           (o_rt),
      .o_rd           (o_rd),
      .o_shamt        (o_shamt),
      .o_funct        (o_funct),
      .o_RegDst       (o_RegDst),
      .o_ALUSrc       (o_ALUSrc),
      .o_MemRead      (o_MemRead),
      .o_MemWrite     (o_MemWrite),
      .o_MemtoReg     (o_MemtoReg),
      .o_RegWrite     (o_RegWrite),
      .o_ALUOp        (o_ALUOp)
   );

   // ---------------- reference model ----------------
   logic [31:0] rf [32];
   logic [31:0] m_rs_data, m_rt_data, m_imm;
   logic [4:0]  m_rs, m_rt, m_rd, m_shamt;
   logic [5:0]  m_funct;
   logic [8:0]  m_ctrl;   // {RegDst,ALUSrc,MemRead,MemWrite,MemtoReg,RegWrite,ALUOp}

   function automatic logic [8:0] ctrl_of(input logic [5:0] op);
      case (op)
         6'b000000: return {6'b100001, 3'd1};
         6'b100011: return {6'b011011, 3'd0};
         6'b101011: return {6'b010100, 3'd0};
         6'b001000: return {6'b010001, 3'd0};
         6'b001100: return {6'b010001, 3'd2};
         6'b001101: return {6'b010001, 3'd3};
         6'b001010: return {6'b010001, 3'd4};
         6'b001111: return {6'b010001, 3'd5};
         default:   return 9'd0;
      endcase
   endfunction

   function automatic logic [31:0] read_reg(input logic [4:0] idx);
      if (idx == 0) return 32'd0;
      if (i_wb_reg_write && i_wb_addr != 0 && i_wb_addr == idx) return i_wb_data;
      return rf[idx];
   endfunction

   function automatic logic exp_stall();
      logic [5:0] op;
      logic [4:0] rs, rt;
      logic uses_rt;
      op = i_instruction[31:26];
      rs = i_instruction[25:21];
      rt = i_instruction[20:16];
      uses_rt = (op == 6'b000000) || (op == 6'b101011) || (op == 6'b000100) ||
                (op == 6'b000101);
      return m_ctrl[6] && (m_rt != 0) && (m_rt == rs || (m_rt == rt && uses_rt));
   endfunction

   function automatic logic exp_pcsrc();
      logic [5:0] op;
      op = i_instruction[31:26];
      if (exp_stall()) return 1'b0;
      if (op == 6'b000100) return read_reg(i_instruction[25:21]) == read_reg(i_instruction[20:16]);
      if (op == 6'b000101) return read_reg(i_instruction[25:21]) != read_reg(i_instruction[20:16]);
      return op == 6'b000010;
   endfunction

   function automatic logic [7:0] exp_pcbranch();
      logic [5:0] op;
      int sum;
      op = i_instruction[31:26];
      sum = (int'(i_PCNext) + int'(i_instruction[7:0])) % 256;
      if (op == 6'b000100 || op == 6'b000101) return 8'(sum);
      if (op == 6'b000010) return i_instruction[7:0];
      return 8'd0;
   endfunction

   function automatic logic [31:0] exp_imm();
      logic signed [15:0] s;
      int ext;
      logic [5:0] op;
      op = i_instruction[31:26];
      if (op == 6'b001100 || op == 6'b001101) return {16'd0, i_instruction[15:0]};
      s = i_instruction[15:0];
      ext = s;
      return ext;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) rf[i] = 32'd0;
      m_rs_data = 0; m_rt_data = 0; m_imm = 0;
      m_rs = 0; m_rt = 0; m_rd = 0; m_shamt = 0; m_funct = 0; m_ctrl = 0;
   endtask

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic check_regs(input string tag);
      check({tag, ".rs_data"}, o_rs_data, m_rs_data);
      check({tag, ".rt_data"}, o_rt_data, m_rt_data);
      check({tag, ".imm"},     o_imm,     m_imm);
      check({tag, ".rs"},      32'(o_rs), 32'(m_rs));
      check({tag, ".rt"},      32'(o_rt), 32'(m_rt));
      check({tag, ".rd"},      32'(o_rd), 32'(m_rd));
      check({tag, ".shamt"},   32'(o_shamt), 32'(m_shamt));
      check({tag, ".funct"},   32'(o_funct), 32'(m_funct));
      check({tag, ".ctrl"}, 32'({o_RegDst, o_ALUSrc, o_MemRead, o_MemWrite, o_MemtoReg,
                                 o_RegWrite, o_ALUOp}), 32'(m_ctrl));
   endtask

   task automatic check_comb(input string tag);
      check({tag, ".stall"},    32'(o_stall),    32'(exp_stall()));
      check({tag, ".PCSrc"},    32'(o_PCSrc),    32'(exp_pcsrc()));
      check({tag, ".PCBranch"}, 32'(o_PCBranch), 32'(exp_pcbranch()));
   endtask

   // One cycle: drive at posedge+1, check comb at negedge, check regs at next posedge+1.
   task automatic step(input string tag, input logic en, input logic [7:0] pcn,
                       input logic [31:0] ins, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd);
      logic st;
      logic [31:0] rsv, rtv, immv;
      enable = en; i_PCNext = pcn; i_instruction = ins;
      i_wb_reg_write = we; i_wb_addr = wa; i_wb_data = wd;
      @(negedge clk);
      check_comb(tag);
      st   = exp_stall();
      rsv  = read_reg(ins[25:21]);
      rtv  = read_reg(ins[20:16]);
      immv = exp_imm();
      @(posedge clk);
      #1;
      if (en) begin
         m_ctrl = st ? 9'd0 : ctrl_of(ins[31:26]);
         m_rs_data = rsv; m_rt_data = rtv; m_imm = immv;
         m_rs = ins[25:21]; m_rt = ins[20:16]; m_rd = ins[15:11];
         m_shamt = ins[10:6]; m_funct = ins[5:0];
         if (we && wa != 0) rf[wa] = wd;
      end
      check_regs(tag);
   endtask

   function automatic logic [31:0] r_type(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
      return {6'b000000, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs, rt,
                                          input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   localparam logic [5:0] RandOps [12] = '{6'b000000, 6'b100011, 6'b101011, 6'b001000,
      6'b001100, 6'b001101, 6'b001010, 6'b001111, 6'b000100, 6'b000101, 6'b000010, 6'b111111};

   initial begin
      logic [31:0] ins;
      logic [5:0]  op;

      model_reset();
      rst = 1'b0; enable = 1'b0; i_PCNext = 0; i_instruction = 0;
      i_wb_reg_write = 0; i_wb_addr = 0; i_wb_data = 0;
      repeat (2) @(posedge clk);
      #1;
      check_regs("reset");
      check_comb("reset");
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // 1: writeback then add $3,$5,$0
      step("t1_wb", 1, 8'h00, 32'd0, 1, 5'd5, 32'h12);
      step("t1_add", 1, 8'h01, r_type(5'd5, 5'd0, 5'd3, 6'h20), 0, 5'd0, 32'd0);
      check("t1_rs_data_const", o_rs_data, 32'h12);
      check("t1_rd_const", 32'(o_rd), 32'd3);
      check("t1_aluop_const", 32'(o_ALUOp), 32'd1);

      // 2: bypass into addi $8,$7,-1; write to $0 is ignored
      step("t2_bypass", 1, 8'h02, i_type(6'b001000, 5'd7, 5'd8, 16'hFFFF), 1, 5'd7, 32'hAB);
      check("t2_rs_data_const", o_rs_data, 32'hAB);
      check("t2_imm_const", o_imm, 32'hFFFF_FFFF);
      step("t2_wr0", 1, 8'h03, 32'd0, 1, 5'd0, 32'h55);
      step("t2_rd0", 1, 8'h04, r_type(5'd0, 5'd7, 5'd9, 6'h20), 1, 5'd0, 32'h66);
      check("t2_reg0_const", o_rs_data, 32'd0);

      // 3: branches
      step("t3_w1", 1, 8'h00, 32'd0, 1, 5'd1, 32'd4);
      step("t3_w2", 1, 8'h00, 32'd0, 1, 5'd2, 32'd4);
      step("t3_beq", 1, 8'h05, i_type(6'b000100, 5'd1, 5'd2, 16'd3), 0, 5'd0, 32'd0);
      step("t3_wrap", 1, 8'hFE, i_type(6'b000100, 5'd1, 5'd2, 16'd3), 0, 5'd0, 32'd0);
      step("t3_w2b", 1, 8'h00, 32'd0, 1, 5'd2, 32'd5);
      step("t3_beq_nt", 1, 8'h05, i_type(6'b000100, 5'd1, 5'd2, 16'd3), 0, 5'd0, 32'd0);
      step("t3_bne", 1, 8'h05, i_type(6'b000101, 5'd1, 5'd2, 16'd3), 0, 5'd0, 32'd0);

      // 4: jump
      step("t4_j", 1, 8'h10, {6'b000010, 26'h40}, 0, 5'd0, 32'd0);
      check("t4_ctrl_const", 32'({o_RegDst, o_ALUSrc, o_MemRead, o_MemWrite, o_MemtoReg,
                                  o_RegWrite, o_ALUOp}), 32'd0);

      // 5: load-use
      step("t5_lw", 1, 8'h20, i_type(6'b100011, 5'd1, 5'd4, 16'd0), 0, 5'd0, 32'd0);
      step("t5_stall", 1, 8'h21, r_type(5'd4, 5'd2, 5'd6, 6'h20), 0, 5'd0, 32'd0);
      check("t5_bubble_const", 32'({o_MemRead, o_RegWrite}), 32'd0);
      step("t5_issue", 1, 8'h21, r_type(5'd4, 5'd2, 5'd6, 6'h20), 0, 5'd0, 32'd0);
      check("t5_issue_const", 32'(o_RegWrite), 32'd1);
      step("t5_lw0", 1, 8'h22, i_type(6'b100011, 5'd1, 5'd0, 16'd0), 0, 5'd0, 32'd0);
      step("t5_nostall", 1, 8'h23, r_type(5'd0, 5'd2, 5'd6, 6'h20), 0, 5'd0, 32'd0);

      // 6: enable low holds state and blocks writes
      for (int i = 0; i < 3; i++)
         step("t6_hold", 0, 8'h30, i_type(6'b001000, 5'd3, 5'd10, 16'h1234), 1, 5'd9, 32'hDEAD);
      step("t6_rd9", 1, 8'h31, r_type(5'd9, 5'd9, 5'd1, 6'h20), 0, 5'd0, 32'd0);
      check("t6_blocked_const", o_rs_data, 32'd0);

      // 7: randomized run, small register range to exercise hazards and bypass
      for (int n = 0; n < 400; n++) begin
         op = RandOps[$urandom_range(11)];
         ins = $urandom;
         ins[31:26] = op;
         ins[25:24] = 2'b00;
         ins[20:19] = 2'b00;
         step("rand", ($urandom_range(7) != 0), 8'($urandom), ins, 1'($urandom),
              5'($urandom_range(7)), $urandom);
      end

      // 8: asynchronous reset mid-cycle
      step("t8_pre", 1, 8'h40, r_type(5'd1, 5'd2, 5'd3, 6'h20), 1, 5'd1, 32'h77);
      i_instruction = 32'd0;
      i_wb_reg_write = 0;
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      check_regs("t8_rst");
      check_comb("t8_rst");
      @(negedge clk);
      rst = 1'b1;
      enable = 1'b0;
      @(posedge clk);
      #1;
      step("t8_after", 1, 8'h00, r_type(5'd1, 5'd2, 5'd3, 6'h20), 0, 5'd0, 32'd0);
      check("t8_reg1_cleared", o_rs_data, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
